// File: rtl/pkt_pkg.sv
// pkt_pkg: shared types and constants for the packet deframer.
//   state_t       - deframer FSM states
//   PKT_PREAMBLE  - default start-of-frame byte
//   PKT_MAX_LEN   - default largest legal payload length
//   *_W           - field widths used across the deframer files
package pkt_pkg;

    localparam int BYTE_W     = 8;
    localparam int ADDR_W     = 4;
    localparam int LEN_W      = 8;
    localparam int PORT_IDX_W = 4;
    localparam int BIT_CNT_W  = 3;

    localparam logic [BYTE_W-1:0] PKT_PREAMBLE = 8'hFE;
    localparam logic [LEN_W-1:0]  PKT_MAX_LEN  = 8'd64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_ADDR    = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4
    } state_t;

endpackage

// File: rtl/pkt_bit_deser.sv
// pkt_bit_deser: MSB-first serial-to-parallel converter.
//   clk        - clock
//   srst       - synchronous active-high reset
//   clr        - clears shift register and bit counter (wins over en)
//   en         - shift din in this cycle
//   din        - serial data bit
//   shift_next - shift register value including the current din
//   byte_done  - high in the sample cycle that captures the 8th bit
module pkt_bit_deser
    import pkt_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [BYTE_W-1:0] shift_next,
    output logic              byte_done
);

    logic [BYTE_W-1:0]    shift_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;

    // The "next" view lets the FSM act on a completed byte in the same
    // cycle its last bit is sampled, so results register one cycle later.
    assign shift_next = {shift_reg[BYTE_W-2:0], din};
    assign byte_done  = en && (bit_cnt_reg == BIT_CNT_W'(BYTE_W - 1));

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (en) begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/pkt_deframer.sv
// pkt_deframer: locks onto one granted serial port, hunts for the preamble,
// then parses an address byte, a length byte and length payload bytes.
//   core_clock - clock;  core_rst - synchronous active-high reset
//   gnt_vec    - arbiter grant (one-hot expected);  din_vec - serial data per port
//   sample_en  - bit strobe for the locked port
//   byte_data/byte_valid              - payload bytes
//   src_addr/dst_addr/pkt_len/hdr_valid - header fields
//   frame_done - last payload byte;  frame_err - frame aborted
//   busy       - not idle;  port_idx - locked port index
module pkt_deframer
    import pkt_pkg::*;
#(
    parameter int                NPORTS   = 9,
    parameter logic [BYTE_W-1:0] PREAMBLE = PKT_PREAMBLE,
    parameter logic [LEN_W-1:0]  MAX_LEN  = PKT_MAX_LEN
) (
    input  logic                  core_clock,
    input  logic                  core_rst,
    input  logic [NPORTS-1:0]     gnt_vec,
    input  logic [NPORTS-1:0]     din_vec,
    input  logic                  sample_en,
    output logic [BYTE_W-1:0]     byte_data,
    output logic                  byte_valid,
    output logic [ADDR_W-1:0]     src_addr,
    output logic [ADDR_W-1:0]     dst_addr,
    output logic [LEN_W-1:0]      pkt_len,
    output logic                  hdr_valid,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  busy,
    output logic [PORT_IDX_W-1:0] port_idx
);

    state_t                state_reg, state_next;
    logic [NPORTS-1:0]     lock_mask_reg, lock_mask_next;
    logic [PORT_IDX_W-1:0] port_idx_reg, port_idx_next;
    logic [LEN_W-1:0]      byte_cnt_reg, byte_cnt_next;
    logic [BYTE_W-1:0]     byte_data_reg, byte_data_next;
    logic [ADDR_W-1:0]     src_addr_reg, src_addr_next;
    logic [ADDR_W-1:0]     dst_addr_reg, dst_addr_next;
    logic [LEN_W-1:0]      pkt_len_reg, pkt_len_next;
    logic                  byte_valid_reg, byte_valid_next;
    logic                  hdr_valid_reg, hdr_valid_next;
    logic                  frame_done_reg, frame_done_next;
    logic                  frame_err_reg, frame_err_next;

    logic [NPORTS-1:0][PORT_IDX_W-1:0] idx_term;
    logic [PORT_IDX_W-1:0] gnt_idx;
    logic                  gnt_onehot;
    logic                  grant_lost;
    logic                  din_sel;
    logic                  deser_en;
    logic                  deser_clr;
    logic [BYTE_W-1:0]     shift_next;
    logic                  byte_done;
    logic                  preamble_hit;
    logic                  len_ok;
    logic                  last_byte;

    // One-hot to index: each grant bit contributes its own index, ORed below.
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_enc
        assign idx_term[gi] = gnt_vec[gi] ? PORT_IDX_W'(gi) : '0;
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            gnt_idx = gnt_idx | idx_term[i];
        end
    end

    assign gnt_onehot = (gnt_vec != '0) && ((gnt_vec & (gnt_vec - NPORTS'(1))) == '0);

    // Any grant other than exactly the locked bit (dropped, moved, or
    // extra bits) counts as a loss.
    assign grant_lost = (gnt_vec != lock_mask_reg);
    assign din_sel    = |(din_vec & lock_mask_reg);

    // A losing grant suppresses the sample so no byte completes that cycle.
    assign deser_en = sample_en && (state_reg != ST_IDLE) && !grant_lost;

    assign preamble_hit = deser_en && (shift_next == PREAMBLE);
    assign len_ok       = (shift_next != '0) && (shift_next <= MAX_LEN);
    assign last_byte    = ((byte_cnt_reg + LEN_W'(1)) == pkt_len_reg);

    pkt_bit_deser u_deser (
        .clk        (core_clock),
        .srst       (core_rst),
        .clr        (deser_clr),
        .en         (deser_en),
        .din        (din_sel),
        .shift_next (shift_next),
        .byte_done  (byte_done)
    );

    // State and registered outputs.
    always_ff @(posedge core_clock) begin
        if (core_rst) begin
            state_reg      <= ST_IDLE;
            lock_mask_reg  <= '0;
            port_idx_reg   <= '0;
            byte_cnt_reg   <= '0;
            byte_data_reg  <= '0;
            src_addr_reg   <= '0;
            dst_addr_reg   <= '0;
            pkt_len_reg    <= '0;
            byte_valid_reg <= 1'b0;
            hdr_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lock_mask_reg  <= lock_mask_next;
            port_idx_reg   <= port_idx_next;
            byte_cnt_reg   <= byte_cnt_next;
            byte_data_reg  <= byte_data_next;
            src_addr_reg   <= src_addr_next;
            dst_addr_reg   <= dst_addr_next;
            pkt_len_reg    <= pkt_len_next;
            byte_valid_reg <= byte_valid_next;
            hdr_valid_reg  <= hdr_valid_next;
            frame_done_reg <= frame_done_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (gnt_onehot) state_next = ST_HUNT;
            end
            ST_HUNT: begin
                if (grant_lost)        state_next = ST_IDLE;
                else if (preamble_hit) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (grant_lost)     state_next = ST_IDLE;
                else if (byte_done) state_next = ST_LEN;
            end
            ST_LEN: begin
                if (grant_lost)     state_next = ST_IDLE;
                else if (byte_done) state_next = len_ok ? ST_PAYLOAD : ST_HUNT;
            end
            ST_PAYLOAD: begin
                if (grant_lost)                  state_next = ST_IDLE;
                else if (byte_done && last_byte) state_next = ST_HUNT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        lock_mask_next  = lock_mask_reg;
        port_idx_next   = port_idx_reg;
        byte_cnt_next   = byte_cnt_reg;
        byte_data_next  = byte_data_reg;
        src_addr_next   = src_addr_reg;
        dst_addr_next   = dst_addr_reg;
        pkt_len_next    = pkt_len_reg;
        byte_valid_next = 1'b0;
        hdr_valid_next  = 1'b0;
        frame_done_next = 1'b0;
        frame_err_next  = 1'b0;
        deser_clr       = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (gnt_onehot) begin
                    lock_mask_next = gnt_vec;
                    port_idx_next  = gnt_idx;
                    // Start hunting with an empty window so stale bits from
                    // a previous session cannot complete a false preamble.
                    deser_clr      = 1'b1;
                end
            end
            ST_HUNT: begin
                // Restart the bit count so ADDR begins on a byte boundary.
                if (preamble_hit) deser_clr = 1'b1;
            end
            ST_ADDR: begin
                if (grant_lost) begin
                    frame_err_next = 1'b1;
                end else if (byte_done) begin
                    src_addr_next = shift_next[BYTE_W-1:ADDR_W];
                    dst_addr_next = shift_next[ADDR_W-1:0];
                end
            end
            ST_LEN: begin
                if (grant_lost) begin
                    frame_err_next = 1'b1;
                end else if (byte_done) begin
                    if (len_ok) begin
                        pkt_len_next   = shift_next;
                        hdr_valid_next = 1'b1;
                        byte_cnt_next  = '0;
                    end else begin
                        frame_err_next = 1'b1;
                        deser_clr      = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (grant_lost) begin
                    frame_err_next = 1'b1;
                end else if (byte_done) begin
                    byte_data_next  = shift_next;
                    byte_valid_next = 1'b1;
                    byte_cnt_next   = byte_cnt_reg + LEN_W'(1);
                    if (last_byte) begin
                        frame_done_next = 1'b1;
                        deser_clr       = 1'b1;
                    end
                end
            end
            default: begin
                deser_clr = 1'b1;
            end
        endcase
    end

    assign byte_data  = byte_data_reg;
    assign byte_valid = byte_valid_reg;
    assign src_addr   = src_addr_reg;
    assign dst_addr   = dst_addr_reg;
    assign pkt_len    = pkt_len_reg;
    assign hdr_valid  = hdr_valid_reg;
    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign port_idx   = port_idx_reg;

endmodule

// File: tb/tb_pkt_deframer.sv
// tb_pkt_deframer: directed scenarios plus randomized sessions checked
// against a bit-level behavioural model of the frame format.
module tb_pkt_deframer;

    localparam int NP = 9;
    localparam logic [7:0] PRE  = 8'hFE;
    localparam int         MAXL = 64;

    logic          core_clock = 1'b0;
    logic          core_rst;
    logic [NP-1:0] gnt_vec;
    logic [NP-1:0] din_vec;
    logic          sample_en;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic [3:0]    src_addr;
    logic [3:0]    dst_addr;
    logic [7:0]    pkt_len;
    logic          hdr_valid;
    logic          frame_done;
    logic          frame_err;
    logic          busy;
    logic [3:0]    port_idx;

    pkt_deframer dut (
        .core_clock (core_clock),
        .core_rst   (core_rst),
        .gnt_vec    (gnt_vec),
        .din_vec    (din_vec),
        .sample_en  (sample_en),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .pkt_len    (pkt_len),
        .hdr_valid  (hdr_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy),
        .port_idx   (port_idx)
    );

    initial forever #5 core_clock = ~core_clock;

    // flags = {hdr_valid, byte_valid, frame_done, frame_err}
    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  flags;
        logic [31:0] val;
    } ev_t;

    ev_t obs_pulse_q[$], exp_pulse_q[$], obs_field_q[$], exp_field_q[$], want_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc_count = 0;
    logic [31:0] obs_field_prev = '0;
    logic [31:0] exp_field_prev = '0;

    // Behavioural model: mode 0 idle, 1 hunting, 2 address, 3 length, 4 payload.
    int         m_mode = 0, m_port = 0, m_win = 0, m_acc = 0, m_nb = 0, m_cnt = 0;
    logic [7:0] m_data = '0, m_len = '0;
    logic [3:0] m_src = '0, m_dst = '0;

    task automatic model_step(input logic [NP-1:0] g, input logic [NP-1:0] d,
                              input logic se, input logic rst);
        logic p_hdr, p_byte, p_done, p_err, lost, b;
        logic [31:0] fv, pv;
        p_hdr = 0; p_byte = 0; p_done = 0; p_err = 0;
        if (rst) begin
            m_mode = 0; m_port = 0; m_win = 0; m_acc = 0; m_nb = 0; m_cnt = 0;
            m_data = '0; m_len = '0; m_src = '0; m_dst = '0;
        end else begin
            b    = d[m_port];
            lost = (g != (NP'(1) << m_port));
            if (m_mode == 0) begin
                if ($countones(g) == 1) begin
                    for (int p = 0; p < NP; p++) if (g[p]) m_port = p;
                    m_mode = 1;
                    m_win  = 0;
                end
            end else if (m_mode == 1) begin
                if (lost) m_mode = 0;
                else if (se) begin
                    m_win = ((m_win << 1) | int'(b)) & 255;
                    if (m_win == int'(PRE)) begin
                        m_mode = 2; m_acc = 0; m_nb = 0;
                    end
                end
            end else begin
                if (lost) begin
                    p_err  = 1;
                    m_mode = 0;
                end else if (se) begin
                    m_acc = ((m_acc << 1) | int'(b)) & 255;
                    m_nb++;
                    if (m_nb == 8) begin
                        m_nb = 0;
                        if (m_mode == 2) begin
                            m_src  = 4'(m_acc >> 4);
                            m_dst  = 4'(m_acc & 15);
                            m_mode = 3;
                        end else if (m_mode == 3) begin
                            if (m_acc >= 1 && m_acc <= MAXL) begin
                                m_len = 8'(m_acc); p_hdr = 1; m_cnt = 0; m_mode = 4;
                            end else begin
                                p_err = 1; m_mode = 1; m_win = 0;
                            end
                        end else begin
                            m_data = 8'(m_acc); p_byte = 1; m_cnt++;
                            if (m_cnt == int'(m_len)) begin
                                p_done = 1; m_mode = 1; m_win = 0;
                            end
                        end
                    end
                end
            end
        end
        pv = {8'h0, p_hdr ? {m_src, m_dst, m_len} : 16'h0, p_byte ? m_data : 8'h0};
        if ({p_hdr, p_byte, p_done, p_err} != 4'h0)
            exp_pulse_q.push_back({32'(cyc_count), p_hdr, p_byte, p_done, p_err, pv});
        fv = {3'b0, m_mode != 0, 4'(m_port), m_data, m_src, m_dst, m_len};
        if (fv != exp_field_prev) exp_field_q.push_back({32'(cyc_count), 4'h0, fv});
        exp_field_prev = fv;
    endtask

    // One clock: drive, let the edge happen, observe #1 later, advance model.
    task automatic step(input logic [NP-1:0] g, input logic [NP-1:0] d,
                        input logic se, input logic rst);
        logic [3:0]  fl;
        logic [31:0] fv, pv;
        gnt_vec = g; din_vec = d; sample_en = se; core_rst = rst;
        @(posedge core_clock);
        #1;
        cyc_count++;
        fl = {hdr_valid, byte_valid, frame_done, frame_err};
        pv = {8'h0, hdr_valid ? {src_addr, dst_addr, pkt_len} : 16'h0, byte_valid ? byte_data : 8'h0};
        if (fl != 4'h0) obs_pulse_q.push_back({32'(cyc_count), fl, pv});
        fv = {3'b0, busy, port_idx, byte_data, src_addr, dst_addr, pkt_len};
        if (fv !== obs_field_prev) obs_field_q.push_back({32'(cyc_count), 4'h0, fv});
        obs_field_prev = fv;
        model_step(g, d, se, rst);
    endtask

    task automatic send_bit(input int port, input logic b, input int gap);
        logic [NP-1:0] d;
        for (int j = 0; j < gap; j++) begin
            d = NP'($urandom);
            d[port] = b;
            step(NP'(1) << port, d, j == 0, 1'b0);
        end
    endtask

    task automatic send_byte(input int port, input logic [7:0] v, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(port, v[i], gap);
    endtask

    task automatic clear_logs();
        obs_pulse_q.delete(); exp_pulse_q.delete();
        obs_field_q.delete(); exp_field_q.delete(); want_q.delete();
    endtask

    task automatic test_reset();
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        checks++;
        if ({byte_data, src_addr, dst_addr, pkt_len} !== 24'h0) begin
            failures++;
            $display("FAIL reset_fields got=%h required=000000", {byte_data, src_addr, dst_addr, pkt_len});
        end
        checks++;
        if ({byte_valid, hdr_valid, frame_done, frame_err, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b required=00000", {byte_valid, hdr_valid, frame_done, frame_err, busy});
        end
        checks++;
        if (port_idx !== 4'h0) begin
            failures++;
            $display("FAIL reset_port_idx got=%0d required=0", port_idx);
        end
    endtask

    task automatic test_normal();
        int s0;
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        step(NP'(1), '0, 1'b0, 1'b0);
        s0 = cyc_count + 1;
        send_bit(0, 1'b0, 1); send_bit(0, 1'b1, 1); send_bit(0, 1'b0, 1);
        send_byte(0, 8'hFE, 1); send_byte(0, 8'h35, 1); send_byte(0, 8'h02, 1);
        send_byte(0, 8'hA5, 1); send_byte(0, 8'h3C, 1);
        want_q.push_back({32'(s0 + 26), 4'h8, 32'h00350200});
        want_q.push_back({32'(s0 + 34), 4'h4, 32'h000000A5});
        want_q.push_back({32'(s0 + 42), 4'h6, 32'h0000003C});
        checks++;
        if (obs_pulse_q.size() != want_q.size()) begin
            failures++;
            $display("FAIL normal_events got=%0d required=%0d", obs_pulse_q.size(), want_q.size());
        end
        for (int i = 0; i < want_q.size() && i < obs_pulse_q.size(); i++) begin
            checks++;
            if (obs_pulse_q[i] !== want_q[i]) begin
                failures++;
                $display("FAIL normal_ev%0d got cyc=%0d flags=%h val=%h required cyc=%0d flags=%h val=%h", i,
                         obs_pulse_q[i].cyc, obs_pulse_q[i].flags, obs_pulse_q[i].val,
                         want_q[i].cyc, want_q[i].flags, want_q[i].val);
            end
        end
    endtask

    task automatic test_gapped();
        int s0;
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        step(NP'(1) << 6, '0, 1'b0, 1'b0);
        checks++;
        if ({busy, port_idx} !== {1'b1, 4'd6}) begin
            failures++;
            $display("FAIL gapped_lock got busy=%b idx=%0d required busy=1 idx=6", busy, port_idx);
        end
        s0 = cyc_count + 1;
        send_bit(6, 1'b0, 3); send_bit(6, 1'b1, 3); send_bit(6, 1'b0, 3);
        send_byte(6, 8'hFE, 3); send_byte(6, 8'h35, 3); send_byte(6, 8'h02, 3);
        send_byte(6, 8'hA5, 3); send_byte(6, 8'h3C, 3);
        want_q.push_back({32'(s0 + 78), 4'h8, 32'h00350200});
        want_q.push_back({32'(s0 + 102), 4'h4, 32'h000000A5});
        want_q.push_back({32'(s0 + 126), 4'h6, 32'h0000003C});
        checks++;
        if (obs_pulse_q.size() != want_q.size()) begin
            failures++;
            $display("FAIL gapped_events got=%0d required=%0d", obs_pulse_q.size(), want_q.size());
        end
        for (int i = 0; i < want_q.size() && i < obs_pulse_q.size(); i++) begin
            checks++;
            if (obs_pulse_q[i] !== want_q[i]) begin
                failures++;
                $display("FAIL gapped_ev%0d got cyc=%0d flags=%h val=%h required cyc=%0d flags=%h val=%h", i,
                         obs_pulse_q[i].cyc, obs_pulse_q[i].flags, obs_pulse_q[i].val,
                         want_q[i].cyc, want_q[i].flags, want_q[i].val);
            end
        end
        checks++;
        if (port_idx !== 4'd6) begin
            failures++;
            $display("FAIL gapped_port_idx got=%0d required=6", port_idx);
        end
    endtask

    task automatic test_bad_len();
        int s0;
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        step(NP'(1), '0, 1'b0, 1'b0);
        s0 = cyc_count + 1;
        send_byte(0, 8'hFE, 1); send_byte(0, 8'h12, 1); send_byte(0, 8'h00, 1);
        send_byte(0, 8'hFE, 1); send_byte(0, 8'h12, 1); send_byte(0, 8'h01, 1);
        send_byte(0, 8'h77, 1);
        want_q.push_back({32'(s0 + 23), 4'h1, 32'h00000000});
        want_q.push_back({32'(s0 + 47), 4'h8, 32'h00120100});
        want_q.push_back({32'(s0 + 55), 4'h6, 32'h00000077});
        checks++;
        if (obs_pulse_q.size() != want_q.size()) begin
            failures++;
            $display("FAIL badlen_events got=%0d required=%0d", obs_pulse_q.size(), want_q.size());
        end
        for (int i = 0; i < want_q.size() && i < obs_pulse_q.size(); i++) begin
            checks++;
            if (obs_pulse_q[i] !== want_q[i]) begin
                failures++;
                $display("FAIL badlen_ev%0d got cyc=%0d flags=%h val=%h required cyc=%0d flags=%h val=%h", i,
                         obs_pulse_q[i].cyc, obs_pulse_q[i].flags, obs_pulse_q[i].val,
                         want_q[i].cyc, want_q[i].flags, want_q[i].val);
            end
        end
    endtask

    task automatic test_grant_drop();
        int s0;
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        step(NP'(1) << 2, '0, 1'b0, 1'b0);
        s0 = cyc_count + 1;
        send_byte(2, 8'hFE, 1); send_byte(2, 8'h35, 1); send_byte(2, 8'h02, 1);
        send_bit(2, 1'b1, 1); send_bit(2, 1'b0, 1); send_bit(2, 1'b1, 1); send_bit(2, 1'b0, 1);
        step('0, NP'($urandom), 1'b1, 1'b0);
        checks++;
        if ({frame_err, busy, byte_valid} !== 3'b100) begin
            failures++;
            $display("FAIL drop_exit got err/busy/bv=%b required=100", {frame_err, busy, byte_valid});
        end
        step('0, NP'($urandom), 1'b1, 1'b0);
        want_q.push_back({32'(s0 + 23), 4'h8, 32'h00350200});
        want_q.push_back({32'(s0 + 28), 4'h1, 32'h00000000});
        checks++;
        if (obs_pulse_q.size() != want_q.size()) begin
            failures++;
            $display("FAIL drop_events got=%0d required=%0d", obs_pulse_q.size(), want_q.size());
        end
        for (int i = 0; i < want_q.size() && i < obs_pulse_q.size(); i++) begin
            checks++;
            if (obs_pulse_q[i] !== want_q[i]) begin
                failures++;
                $display("FAIL drop_ev%0d got cyc=%0d flags=%h val=%h required cyc=%0d flags=%h val=%h", i,
                         obs_pulse_q[i].cyc, obs_pulse_q[i].flags, obs_pulse_q[i].val,
                         want_q[i].cyc, want_q[i].flags, want_q[i].val);
            end
        end
    endtask

    task automatic test_multi_hot();
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            step(NP'(3), NP'($urandom), 1'b1, 1'b0);
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL multihot_busy cycle=%0d got=%b required=0", i, busy);
            end
        end
        checks++;
        if (obs_pulse_q.size() != 0) begin
            failures++;
            $display("FAIL multihot_events got=%0d required=0", obs_pulse_q.size());
        end
    endtask

    task automatic test_reset_mid_payload();
        int s0;
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        step(NP'(1) << 1, '0, 1'b0, 1'b0);
        s0 = cyc_count + 1;
        send_byte(1, 8'hFE, 1); send_byte(1, 8'h35, 1); send_byte(1, 8'h02, 1);
        send_bit(1, 1'b1, 1); send_bit(1, 1'b0, 1); send_bit(1, 1'b1, 1); send_bit(1, 1'b0, 1);
        step(NP'(1) << 1, NP'($urandom), 1'b1, 1'b1);
        checks++;
        if ({byte_data, byte_valid, src_addr, dst_addr, pkt_len, hdr_valid, frame_done, frame_err, busy, port_idx} !== 37'h0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h required=0",
                     {byte_data, byte_valid, src_addr, dst_addr, pkt_len, hdr_valid, frame_done, frame_err, busy, port_idx});
        end
        step(NP'(1) << 1, NP'($urandom), 1'b0, 1'b0);
        checks++;
        if ({frame_err, busy} !== 2'b01) begin
            failures++;
            $display("FAIL midrst_after got err/busy=%b required=01", {frame_err, busy});
        end
        want_q.push_back({32'(s0 + 23), 4'h8, 32'h00350200});
        checks++;
        if (obs_pulse_q.size() != want_q.size()) begin
            failures++;
            $display("FAIL midrst_events got=%0d required=%0d", obs_pulse_q.size(), want_q.size());
        end
        for (int i = 0; i < want_q.size() && i < obs_pulse_q.size(); i++) begin
            checks++;
            if (obs_pulse_q[i] !== want_q[i]) begin
                failures++;
                $display("FAIL midrst_ev%0d got cyc=%0d flags=%h val=%h required cyc=%0d flags=%h val=%h", i,
                         obs_pulse_q[i].cyc, obs_pulse_q[i].flags, obs_pulse_q[i].val,
                         want_q[i].cyc, want_q[i].flags, want_q[i].val);
            end
        end
    endtask

    task automatic test_random();
        step('0, '0, 1'b0, 1'b1);
        clear_logs();
        for (int s = 0; s < 30; s++) begin
            int         p, gap, nfr, junk, r, disturb_at, kind, q;
            logic [7:0] len;
            logic [7:0] v;
            logic       bits_q[$];
            p   = $urandom_range(0, NP - 1);
            gap = $urandom_range(1, 3);
            nfr = $urandom_range(1, 2);
            for (int f = 0; f < nfr; f++) begin
                junk = $urandom_range(0, 5);
                for (int j = 0; j < junk; j++) bits_q.push_back(1'($urandom));
                r = $urandom_range(0, 9);
                if (r == 0)      len = 8'd0;
                else if (r == 1) len = 8'd65;
                else if (r == 2) len = 8'd64;
                else if (r == 3) len = 8'($urandom_range(66, 255));
                else             len = 8'($urandom_range(1, 5));
                for (int k = 0; k < 3; k++) begin
                    v = (k == 0) ? PRE : (k == 1) ? 8'($urandom) : len;
                    for (int i = 7; i >= 0; i--) bits_q.push_back(v[i]);
                end
                if (len >= 8'd1 && len <= 8'(MAXL)) begin
                    for (int k = 0; k < int'(len); k++) begin
                        v = 8'($urandom);
                        for (int i = 7; i >= 0; i--) bits_q.push_back(v[i]);
                    end
                end
            end
            disturb_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, bits_q.size() - 1) : -1;
            kind = $urandom_range(0, 3);
            q    = (p + 1 + $urandom_range(0, NP - 2)) % NP;
            step(NP'(1) << p, NP'($urandom), 1'b0, 1'b0);
            for (int k = 0; k < bits_q.size(); k++) begin
                if (k == disturb_at) begin
                    if (kind == 0)      step('0, NP'($urandom), 1'b1, 1'b0);
                    else if (kind == 1) step(NP'(1) << q, NP'($urandom), 1'b1, 1'b0);
                    else if (kind == 2) step(NP'(1) << p, NP'($urandom), 1'b1, 1'b1);
                    else                step((NP'(1) << p) | (NP'(1) << q), NP'($urandom), 1'b1, 1'b0);
                end
                send_bit(p, bits_q[k], gap);
            end
            step('0, NP'($urandom), 1'b1, 1'b0);
        end
        checks++;
        if (obs_pulse_q.size() != exp_pulse_q.size()) begin
            failures++;
            $display("FAIL random_pulse_count got=%0d required=%0d", obs_pulse_q.size(), exp_pulse_q.size());
        end
        for (int i = 0; i < exp_pulse_q.size() && i < obs_pulse_q.size(); i++) begin
            checks++;
            if (obs_pulse_q[i] !== exp_pulse_q[i]) begin
                failures++;
                $display("FAIL random_pulse%0d got cyc=%0d flags=%h val=%h required cyc=%0d flags=%h val=%h", i,
                         obs_pulse_q[i].cyc, obs_pulse_q[i].flags, obs_pulse_q[i].val,
                         exp_pulse_q[i].cyc, exp_pulse_q[i].flags, exp_pulse_q[i].val);
            end
        end
        checks++;
        if (obs_field_q.size() != exp_field_q.size()) begin
            failures++;
            $display("FAIL random_field_count got=%0d required=%0d", obs_field_q.size(), exp_field_q.size());
        end
        for (int i = 0; i < exp_field_q.size() && i < obs_field_q.size(); i++) begin
            checks++;
            if (obs_field_q[i] !== exp_field_q[i]) begin
                failures++;
                $display("FAIL random_field%0d got cyc=%0d val=%h required cyc=%0d val=%h", i,
                         obs_field_q[i].cyc, obs_field_q[i].val, exp_field_q[i].cyc, exp_field_q[i].val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_gapped();
        test_bad_len();
        test_grant_drop();
        test_multi_hot();
        test_reset_mid_payload();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
